// File: rtl/div_pkg.sv
// Shared types and defaults for the restoring divider.
package div_pkg;
  localparam int unsigned DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;
endpackage

// File: rtl/prefix_subtractor.sv
// N-bit Sklansky parallel-prefix subtractor: diff = a + ~b + 1, borrow = ~carry_out.
module prefix_subtractor #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  localparam int unsigned LEVELS = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] h;
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] gn;
  logic [N-1:0] pn;

  always_comb begin
    h  = a ^ ~b;
    p  = h;
    g  = a & ~b;
    // Carry-in of 1 is folded into the bit-0 generate term.
    g[0] = g[0] | p[0];
    gn = g;
    pn = p;
    for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
      gn = g;
      pn = p;
      for (int unsigned i = 0; i < N; i++) begin
        if (((i >> lvl) & 1) != 0) begin
          gn[i] = g[i] | (p[i] & g[((i >> lvl) << lvl) - 1]);
          pn[i] = p[i] & p[((i >> lvl) << lvl) - 1];
        end
      end
      g = gn;
      p = pn;
    end
    diff   = h ^ {g[N-2:0], 1'b1};
    borrow = ~g[N-1];
  end
endmodule

// File: rtl/restoring_divider8.sv
// Multi-cycle unsigned restoring divider with valid/ready handshakes on both sides.
module restoring_divider8
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             rdy_q;
  logic             vld_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             rem_top_unused;

  // The restored partial remainder is always below the divisor, so its top bit stays clear.
  assign shifted        = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign rem_top_unused = rem_q[WIDTH];

  prefix_subtractor #(
    .N(WIDTH + 1)
  ) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = dividend;
          dvs_d = divisor;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = {1'b0, dividend};
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            quo_d   = '0;
            rem_d   = '0;
            dbz_d   = 1'b0;
          end
        end
      end
      CALC: begin
        dvd_d = dvd_q << 1;
        rem_d = borrow ? shifted : diff;
        quo_d = {quo_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      rdy_q   <= (state_d == IDLE);
      vld_q   <= (state_d == DONE);
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = vld_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q[WIDTH-1:0];
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider8.sv
// Self-checking bench: arithmetic reference model plus directed literal cases and random stalls.
module tb_restoring_divider8;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;
  bit prev_deliver = 1'b0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int unsigned  lat;
    int unsigned  t;
    bit           seen;
  } exp_t;

  exp_t expq[$];

  restoring_divider8 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = W + 1;
    end
    e.t    = cyc;
    e.seen = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      prev_deliver = 1'b0;
    end else begin
      chk("ready_valid_exclusive", {31'd0, in_ready && out_valid}, 0);
      if (prev_deliver) chk("in_ready_after_handshake", {31'd0, in_ready}, 1);
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_out_valid", {31'd0, out_valid}, 0);
        end else begin
          chk("quotient", {24'd0, quotient}, {24'd0, expq[0].q});
          chk("remainder", {24'd0, remainder}, {24'd0, expq[0].r});
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, expq[0].dbz});
          if (!expq[0].seen) begin
            chk("latency", cyc - expq[0].t, expq[0].lat);
            expq[0].seen = 1'b1;
          end
          if (out_ready) void'(expq.pop_front());
        end
      end
      prev_deliver = out_valid && out_ready;
      if (in_valid && in_ready) expq.push_back(model(dividend, divisor));
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int unsigned hold_low, input bit rnd, input bit lit,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input int unsigned elat);
    int unsigned n;
    int unsigned low;
    int unsigned first;
    bit got;
    bit done;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = in_ready;
      if (!got) begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      chk("accept_timeout", {31'd0, in_ready}, 1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    dividend  = W'($urandom);
    divisor   = W'($urandom);
    out_ready = rnd ? 1'($urandom_range(0, 1)) : (hold_low == 0);
    n = 0; low = 0; first = 0; done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid && first == 0) first = n;
      if (out_valid && out_ready) begin
        done = 1'b1;
      end else begin
        if (out_valid) low++;
        @(posedge clk); #1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : (low >= hold_low);
      end
    end
    if (!done) begin
      chk("deliver_timeout", {31'd0, out_valid}, 1);
    end else if (lit) begin
      chk("lit_quotient", {24'd0, quotient}, {24'd0, eq});
      chk("lit_remainder", {24'd0, remainder}, {24'd0, er});
      chk("lit_div_by_zero", {31'd0, div_by_zero}, {31'd0, edbz});
      chk("lit_latency", first, elat);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_quotient", {24'd0, quotient}, 0);
    chk("rst_remainder", {24'd0, remainder}, 0);
    chk("rst_div_by_zero", {31'd0, div_by_zero}, 0);
    @(posedge clk); #1;

    run_op(8'd200, 8'd7, 0, 1'b0, 1'b1, 8'd28, 8'd4, 1'b0, 9);
    run_op(8'd255, 8'd1, 1, 1'b0, 1'b1, 8'd255, 8'd0, 1'b0, 9);
    run_op(8'd5, 8'd9, 0, 1'b0, 1'b1, 8'd0, 8'd5, 1'b0, 9);
    run_op(8'd0, 8'd3, 0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 9);
    run_op(8'd100, 8'd0, 2, 1'b0, 1'b1, 8'hFF, 8'd100, 1'b1, 1);
    run_op(8'd128, 8'd3, 5, 1'b0, 1'b1, 8'd42, 8'd2, 1'b0, 9);
    @(negedge clk);
    chk("in_ready_after_stall", {31'd0, in_ready}, 1);
    @(posedge clk); #1;

    // Abort 77/5 with reset during its fourth CALC cycle.
    in_valid = 1'b1; dividend = 8'd77; divisor = 8'd5;
    @(negedge clk);
    chk("accept_77", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_abort", {31'd0, in_ready}, 1);
    chk("no_valid_after_abort", {31'd0, out_valid}, 0);
    repeat (12) begin
      @(negedge clk);
      chk("quiet_after_abort", {31'd0, out_valid}, 0);
    end
    @(posedge clk); #1;
    run_op(8'd77, 8'd5, 0, 1'b0, 1'b1, 8'd15, 8'd2, 1'b0, 9);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 8'd1;
        2:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      ra = W'($urandom);
      run_op(ra, rb, 0, 1'b1, 1'b0, '0, '0, 1'b0, 0);
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/restoring_divider8.md
RESTORING_DIVIDER8 -- requirements
Module: restoring_divider8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: dividend/divisor presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 The block SHALL have port dividend, input, WIDTH bits: unsigned dividend.
REQ-007 The block SHALL have port divisor, input, WIDTH bits: unsigned divisor.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result presented.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port quotient, output, WIDTH bits: unsigned quotient.
REQ-011 The block SHALL have port remainder, output, WIDTH bits: unsigned remainder.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: divisor was zero.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, when in_valid=1, the block SHALL register dividend and divisor and leave IDLE; while in_valid=0 it SHALL stay in IDLE.
REQ-015 When the registered divisor is 0, the FSM SHALL go IDLE->DONE with quotient={WIDTH{1}}, remainder=dividend and div_by_zero=1, so that out_valid rises one cycle after acceptance.
REQ-016 When the divisor is nonzero, the FSM SHALL go IDLE->CALC with the partial remainder (WIDTH+1 bits) cleared and the iteration counter at 0.
REQ-017 In each CALC cycle: partial remainder SHALL shift left by one, taking in the next dividend MSB; the registered divisor SHALL be trial-subtracted; on no borrow the remainder SHALL take the difference and the quotient bit SHALL be 1, else the remainder SHALL be kept and the quotient bit SHALL be 0.
REQ-018 After exactly WIDTH CALC cycles the FSM SHALL enter DONE; out_valid SHALL rise WIDTH+1 cycles after the accept edge (9 for WIDTH=8).
REQ-019 In DONE, quotient, remainder and div_by_zero SHALL hold stable while out_ready=0.
REQ-020 On out_valid=1 and out_ready=1 the FSM SHALL return to IDLE; in_ready SHALL rise the following cycle, and the block SHALL NOT accept in the same cycle as delivery.
REQ-021 Changes on dividend/divisor after acceptance SHALL NOT affect the result.
REQ-022 All outputs SHALL be driven from registers; no combinational path SHALL exist from in_valid/out_ready to any output.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every nonzero divisor, including dividend < divisor (quotient 0) and divisor 1.
REQ-024 Only div_by_zero=1 SHALL produce the all-ones quotient pattern for divisor 0.

Reset
REQ-025 rst=1 SHALL force state IDLE, in_ready=1 (from the following cycle), out_valid=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter and partial remainder.
REQ-026 rst during CALC or DONE SHALL abandon the operation with no out_valid pulse; rst SHALL take priority over every handshake.

Structure
REQ-027 Package div_pkg SHALL hold the state enum (IDLE, CALC, DONE) and the constant DIV_WIDTH_DEFAULT=8.
REQ-028 The trial subtraction SHALL be a sub-module prefix_subtractor: a (WIDTH+1)-bit Sklansky parallel-prefix subtractor computing A + ~B + 1, with outputs diff and borrow.
REQ-029 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-030 A bench SHALL cover: 200/7 -> quotient 28, remainder 4, div_by_zero 0, out_valid 9 cycles after accept.
REQ-031 A bench SHALL cover: 255/1 -> 255 r 0; 5/9 -> 0 r 5; 0/3 -> 0 r 0.
REQ-032 A bench SHALL cover: 100/0 -> quotient 8'hFF, remainder 100, div_by_zero 1, out_valid 1 cycle after accept.
REQ-033 A bench SHALL cover: 128/3 with out_ready held low 5 cycles -> 42 r 2 stable throughout, then in_ready 1 the cycle after the handshake.
REQ-034 A bench SHALL cover: rst asserted on the 4th CALC cycle of 77/5 -> no out_valid, IDLE next cycle, and a following 77/5 gives 15 r 2.
REQ-035 A bench SHALL run random back-to-back operations against the reference equation with random out_ready stalls.
